// File: rtl/intr_event_collector.sv
// Per-source interrupt event collector: synchronizes raw events, holds a level request
// until acknowledged, enforces a post-ack holdoff and counts overflowed events.
module intr_event_collector #(
  parameter int                 NUM_SRC        = 4,
  parameter int                 SYNC_STAGES    = 2,
  parameter logic [NUM_SRC-1:0] EDGE_MODE      = {NUM_SRC{1'b1}},
  parameter int                 HOLDOFF_CYCLES = 4,
  parameter int                 CNT_WIDTH      = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [NUM_SRC-1:0]             src_in,
  input  logic [NUM_SRC-1:0]             src_en,
  input  logic [NUM_SRC-1:0]             intr_ack,
  input  logic                           ovf_clr,
  output logic [NUM_SRC-1:0]             intr_out,
  output logic [NUM_SRC*CNT_WIDTH-1:0]   ovf_cnt,
  output logic                           any_pending
);

  typedef enum logic [1:0] {IDLE, PENDING, HOLDOFF} state_t;

  logic [SYNC_STAGES-1:0] sync_q  [NUM_SRC];
  state_t                 state_q [NUM_SRC];
  state_t                 state_d [NUM_SRC];
  logic [7:0]             hold_q  [NUM_SRC];
  logic [7:0]             hold_d  [NUM_SRC];
  logic [CNT_WIDTH-1:0]   cnt_q   [NUM_SRC];
  logic [CNT_WIDTH-1:0]   cnt_d   [NUM_SRC];

  logic [NUM_SRC-1:0] sync_out;
  logic [NUM_SRC-1:0] hist_q;
  logic [NUM_SRC-1:0] qual_evt;
  logic [NUM_SRC-1:0] defer_q;
  logic [NUM_SRC-1:0] defer_d;
  logic [NUM_SRC-1:0] intr_d;
  logic [NUM_SRC-1:0] inc;
  logic [NUM_SRC-1:0] defer_next;

  // Edge sources fire once per rising synchronized level; level sources fire every cycle.
  always_comb begin
    sync_out = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign qual_evt = (sync_out & (~hist_q | ~EDGE_MODE)) & src_en;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    inc        = '0;
    defer_next = '0;
    defer_d    = defer_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (qual_evt[i]) state_d[i] = PENDING;
        end
        PENDING: begin
          if (intr_ack[i]) begin
            // An event coincident with the ack is deferred rather than counted.
            state_d[i] = HOLDOFF;
            hold_d[i]  = 8'(HOLDOFF_CYCLES);
            defer_d[i] = qual_evt[i];
          end else begin
            inc[i] = qual_evt[i] & EDGE_MODE[i];
          end
        end
        HOLDOFF: begin
          inc[i]        = qual_evt[i] & defer_q[i] & EDGE_MODE[i];
          defer_next[i] = defer_q[i] | qual_evt[i];
          if (hold_q[i] == 8'd1) begin
            state_d[i] = defer_next[i] ? PENDING : IDLE;
            defer_d[i] = 1'b0;
          end else begin
            hold_d[i]  = hold_q[i] - 8'd1;
            defer_d[i] = defer_next[i];
          end
        end
        default: state_d[i] = IDLE;
      endcase

      // Clear takes priority over a simultaneous increment.
      if (ovf_clr)                               cnt_d[i] = '0;
      else if (inc[i] && (cnt_q[i] != '1))       cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      else                                       cnt_d[i] = cnt_q[i];

      intr_d[i] = (state_d[i] == PENDING);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        sync_q[i]  <= '0;
        state_q[i] <= IDLE;
        hold_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      hist_q      <= '0;
      defer_q     <= '0;
      intr_out    <= '0;
      any_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], src_in[i]};
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      hist_q      <= sync_out;
      defer_q     <= defer_d;
      intr_out    <= intr_d;
      any_pending <= |intr_d;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ovf
    assign ovf_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule

// File: tb/tb_intr_event_collector.sv
// Directed bench for intr_event_collector: 4 sources, source 1 level-mode, holdoff of 4.
module tb_intr_event_collector;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  src_in;
  logic [3:0]  src_en;
  logic [3:0]  intr_ack;
  logic        ovf_clr;
  logic [3:0]  intr_out;
  logic [31:0] ovf_cnt;
  logic        any_pending;

  int total = 0;
  int bad   = 0;

  intr_event_collector #(
    .NUM_SRC(4), .SYNC_STAGES(2), .EDGE_MODE(4'b1101),
    .HOLDOFF_CYCLES(4), .CNT_WIDTH(8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .src_in(src_in), .src_en(src_en),
    .intr_ack(intr_ack), .ovf_clr(ovf_clr), .intr_out(intr_out),
    .ovf_cnt(ovf_cnt), .any_pending(any_pending)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  function automatic logic [7:0] ovf(input int i);
    return ovf_cnt[i*8 +: 8];
  endfunction

  // One 0->1 transition on src_in[0]; the rising level is sampled at the second edge.
  task automatic edge0();
    src_in[0] = 1'b0;
    tick(1);
    src_in[0] = 1'b1;
    tick(1);
  endtask

  task automatic ack(input logic [3:0] bits);
    intr_ack = bits;
    tick(1);
    intr_ack = '0;
  endtask

  // Called right after the ack edge: four low cycles, then re-assertion.
  task automatic expect_reassert(input string tag, input int b);
    check({tag, "_low0"}, 32'(intr_out[b]), 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick(1);
      check({tag, "_low"}, 32'(intr_out[b]), 32'd0);
    end
    tick(1);
    check({tag, "_re"}, 32'(intr_out[b]), 32'd1);
  endtask

  initial begin
    ARESET = 1'b1; src_in = '0; src_en = '0; intr_ack = '0; ovf_clr = 1'b0;
    tick(3);
    check("rst_intr", 32'(intr_out), 32'd0);
    check("rst_any", 32'(any_pending), 32'd0);
    check("rst_ovf", ovf_cnt, 32'd0);
    ARESET = 1'b0;
    src_en = 4'hF;
    tick(2);

    // Latency and basic ack/holdoff on edge source 0.
    src_in[0] = 1'b1;
    tick(1);
    check("lat_n", 32'(intr_out[0]), 32'd0);
    tick(1);
    check("lat_n1", 32'(intr_out[0]), 32'd0);
    tick(1);
    check("lat_n2", 32'(intr_out[0]), 32'd1);
    check("lat_any", 32'(any_pending), 32'd1);
    tick(3);
    check("hold_pend", 32'(intr_out[0]), 32'd1);
    ack(4'b0001);
    for (int k = 0; k < 4; k++) begin
      check("ho_low", 32'(intr_out[0]), 32'd0);
      tick(1);
    end
    tick(3);
    check("ho_idle", 32'(intr_out[0]), 32'd0);
    check("ho_idle_any", 32'(any_pending), 32'd0);

    // Overflow counting, saturation and clear-over-increment.
    edge0();
    tick(2);
    check("ovf_pend", 32'(intr_out[0]), 32'd1);
    check("ovf_zero", 32'(ovf(0)), 32'd0);
    repeat (3) edge0();
    tick(2);
    check("ovf_three", 32'(ovf(0)), 32'd3);
    repeat (300) edge0();
    tick(2);
    check("ovf_sat", 32'(ovf(0)), 32'd255);
    edge0();
    tick(1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr_win", 32'(ovf(0)), 32'd0);
    tick(3);
    check("ovf_clr_hold", 32'(ovf(0)), 32'd0);
    ack(4'b0001);
    tick(6);
    check("ovf_ack_idle", 32'(intr_out[0]), 32'd0);

    // Edge during holdoff is deferred and re-asserts.
    edge0();
    tick(2);
    check("def_pend", 32'(intr_out[0]), 32'd1);
    intr_ack[0] = 1'b1;
    src_in[0]   = 1'b0;
    tick(1);
    intr_ack[0] = 1'b0;
    src_in[0]   = 1'b1;
    expect_reassert("def1", 0);
    check("def1_ovf", 32'(ovf(0)), 32'd0);

    // Event coincident with ack, then a second event in holdoff: one overflow.
    src_in[0] = 1'b0; tick(1);
    src_in[0] = 1'b1; tick(1);
    src_in[0] = 1'b0; tick(1);
    src_in[0] = 1'b1; intr_ack[0] = 1'b1; tick(1);
    intr_ack[0] = 1'b0;
    expect_reassert("def2", 0);
    check("def2_ovf", 32'(ovf(0)), 32'd1);

    // Ack and event in the same cycle: holdoff then re-assert, no count.
    src_in[0] = 1'b0; tick(1);
    src_in[0] = 1'b1; tick(2);
    intr_ack[0] = 1'b1; tick(1);
    intr_ack[0] = 1'b0;
    expect_reassert("coin", 0);
    check("coin_ovf", 32'(ovf(0)), 32'd1);
    ack(4'b0001);
    tick(6);
    check("coin_idle", 32'(intr_out[0]), 32'd0);

    // Level source 1 held high.
    src_in[1] = 1'b1;
    tick(2);
    check("lvl_n1", 32'(intr_out[1]), 32'd0);
    tick(1);
    check("lvl_n2", 32'(intr_out[1]), 32'd1);
    tick(5);
    check("lvl_pend_ovf", 32'(ovf(1)), 32'd0);
    ack(4'b0010);
    expect_reassert("lvl", 1);
    check("lvl_ovf", 32'(ovf(1)), 32'd0);
    src_in[1] = 1'b0;
    tick(4);
    ack(4'b0010);
    tick(6);
    check("lvl_idle", 32'(intr_out[1]), 32'd0);
    check("lvl_any", 32'(any_pending), 32'd0);

    // Disabled source drops events.
    src_en = 4'b1011;
    src_in[2] = 1'b1;
    tick(6);
    check("dis_intr", 32'(intr_out[2]), 32'd0);
    check("dis_ovf", 32'(ovf(2)), 32'd0);
    src_en = 4'hF;
    tick(4);
    check("dis_late", 32'(intr_out[2]), 32'd0);

    // Disabling does not clear pending; reset mid-pending clears everything.
    src_in[3] = 1'b1;
    tick(3);
    check("en_pend", 32'(intr_out[3]), 32'd1);
    src_en = 4'b0111;
    tick(3);
    check("en_keep", 32'(intr_out[3]), 32'd1);
    check("pre_rst_ovf", 32'(ovf(0)), 32'd1);
    ARESET = 1'b1;
    tick(1);
    check("mid_rst_intr", 32'(intr_out), 32'd0);
    check("mid_rst_any", 32'(any_pending), 32'd0);
    check("mid_rst_ovf", ovf_cnt, 32'd0);
    tick(2);
    ARESET = 1'b0;
    src_en = 4'hF;

    // Inputs held high through reset release give exactly one event each.
    tick(3);
    check("rel_intr", 32'(intr_out), 32'b1101);
    ack(4'b1000);
    check("rel_ack3", 32'(intr_out), 32'b0101);
    tick(8);
    check("rel_once", 32'(intr_out), 32'b0101);
    check("rel_any", 32'(any_pending), 32'd1);
    check("rel_ovf", ovf_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
